// File: rtl/lif_neuron_array.sv
// Array of N_CH leaky integrate-and-fire neurons with runtime threshold, leak and
// refractory configuration, a membrane readback mux and a wrapping spike counter.
module lif_neuron_array #(
  parameter int WIDTH       = 8,
  parameter int N_CH        = 4,
  parameter int REF_W       = 3,
  parameter int THRESH_INIT = 200,
  parameter int LEAK_INIT   = 1,
  parameter int REFRAC_INIT = 2,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [N_CH*WIDTH-1:0] current,
  input  logic                  cfg_we,
  input  logic [WIDTH-1:0]      cfg_threshold,
  input  logic [2:0]            cfg_leak_shift,
  input  logic [REF_W-1:0]      cfg_refrac,
  input  logic [SEL_W-1:0]      state_sel,
  output logic [N_CH-1:0]       spike_out,
  output logic [WIDTH-1:0]      state_out,
  output logic [15:0]           spike_total
);

  logic [WIDTH-1:0] threshold;
  logic [2:0]       leak_shift;
  logic [REF_W-1:0] refrac;

  logic [WIDTH-1:0] u_all [N_CH];
  logic [N_CH-1:0]  spike_next;
  logic [15:0]      spike_count;

  // Config registers only feed the neuron update on the edge after they are written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      threshold  <= WIDTH'(THRESH_INIT);
      leak_shift <= 3'(LEAK_INIT);
      refrac     <= REF_W'(REFRAC_INIT);
    end else if (cfg_we) begin
      threshold  <= cfg_threshold;
      leak_shift <= cfg_leak_shift;
      refrac     <= cfg_refrac;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [WIDTH-1:0] u_q, u_d;
    logic [REF_W-1:0] r_q, r_d;
    logic             spike_d;
    logic [WIDTH-1:0] cur_k;
    logic [WIDTH-1:0] leaked;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat;
    logic             fire;

    assign cur_k  = current[k*WIDTH +: WIDTH];
    // Shifts of WIDTH or more clear u>>leak, which leaves leaked equal to u.
    assign leaked = (leak_shift == 3'd0) ? u_q : u_q - (u_q >> leak_shift);
    assign sum    = {1'b0, leaked} + {1'b0, cur_k};
    assign sat    = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    assign fire   = (sat >= threshold);

    always_comb begin
      u_d     = u_q;
      r_d     = r_q;
      spike_d = 1'b0;
      if (ena) begin
        if (r_q != '0) begin
          r_d = r_q - REF_W'(1);
          u_d = '0;
        end else if (fire) begin
          spike_d = 1'b1;
          u_d     = '0;
          r_d     = refrac;
        end else begin
          u_d = sat;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        u_q <= '0;
        r_q <= '0;
      end else begin
        u_q <= u_d;
        r_q <= r_d;
      end
    end

    assign u_all[k]      = u_q;
    assign spike_next[k] = spike_d;
  end

  always_comb begin
    spike_count = '0;
    for (int k = 0; k < N_CH; k++) begin
      spike_count = spike_count + 16'(spike_next[k]);
    end
  end

  // The counter adds the spikes being registered this edge, so it always matches spike_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_out   <= '0;
      spike_total <= '0;
    end else begin
      spike_out   <= spike_next;
      spike_total <= spike_total + spike_count;
    end
  end

  always_comb begin
    state_out = '0;
    if (int'(state_sel) < N_CH) begin
      state_out = u_all[state_sel];
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed vector table, hand-written corner
// sequences and randomized traffic compared against an integer reference model.
module tb_lif_neuron_array;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [31:0] current;
  logic        cfg_we;
  logic [7:0]  cfg_threshold;
  logic [2:0]  cfg_leak_shift;
  logic [2:0]  cfg_refrac;
  logic [1:0]  state_sel;
  logic [3:0]  spike_out;
  logic [7:0]  state_out;
  logic [15:0] spike_total;

  logic [47:0] current6;
  logic [2:0]  state_sel6;
  logic [5:0]  spike_out6;
  logic [7:0]  state_out6;
  logic [15:0] spike_total6;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state for the 4-channel instance.
  int m_u[4];
  int m_r[4];
  int m_spk[4];
  int m_thr, m_leak, m_ref, m_total;

  typedef struct {
    logic        rst_n;
    logic        ena;
    logic [31:0] cur;
    int          exp_state;
    int          exp_spike;
    int          exp_total;
  } vec_t;

  vec_t tbl[13];

  lif_neuron_array dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .current(current),
    .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
    .cfg_refrac(cfg_refrac), .state_sel(state_sel),
    .spike_out(spike_out), .state_out(state_out), .spike_total(spike_total)
  );

  lif_neuron_array #(.N_CH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .current(current6),
    .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
    .cfg_refrac(cfg_refrac), .state_sel(state_sel6),
    .spike_out(spike_out6), .state_out(state_out6), .spike_total(spike_total6)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Applies the rules to the inputs present at this edge, then latches any config write.
  task automatic modelEdge();
    int cnt, i_k, leaked, sum;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_u[k] = 0; m_r[k] = 0; m_spk[k] = 0;
      end
      m_thr = 200; m_leak = 1; m_ref = 2; m_total = 0;
      return;
    end
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (!ena) begin
        m_spk[k] = 0;
      end else if (m_r[k] != 0) begin
        m_r[k]   = m_r[k] - 1;
        m_u[k]   = 0;
        m_spk[k] = 0;
      end else begin
        i_k    = int'(current[8*k +: 8]);
        leaked = (m_leak == 0 || m_leak >= 8) ? m_u[k] : m_u[k] - m_u[k] / (1 << m_leak);
        sum    = leaked + i_k;
        if (sum > 255) sum = 255;
        if (sum >= m_thr) begin
          m_spk[k] = 1; m_u[k] = 0; m_r[k] = m_ref;
        end else begin
          m_spk[k] = 0; m_u[k] = sum;
        end
      end
      cnt += m_spk[k];
    end
    m_total = (m_total + cnt) % 65536;
    if (cfg_we) begin
      m_thr  = int'(cfg_threshold);
      m_leak = int'(cfg_leak_shift);
      m_ref  = int'(cfg_refrac);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkModel(input string tag);
    int exp_spk;
    exp_spk = 0;
    for (int k = 0; k < 4; k++) if (m_spk[k] != 0) exp_spk |= (1 << k);
    checkOutput({tag, " spike_out"}, int'(spike_out), exp_spk);
    checkOutput({tag, " spike_total"}, int'(spike_total), m_total);
    for (int k = 0; k < 4; k++) begin
      state_sel = 2'(k);
      #1;
      checkOutput($sformatf("%s state_out[%0d]", tag, k), int'(state_out), m_u[k]);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
  endtask

  task automatic writeCfg(input int thr, input int leak, input int refr);
    ena = 1'b0; cfg_we = 1'b1;
    cfg_threshold = 8'(thr); cfg_leak_shift = 3'(leak); cfg_refrac = 3'(refr);
    applyStimulus();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; current = '0; cfg_we = 1'b0;
    cfg_threshold = '0; cfg_leak_shift = '0; cfg_refrac = '0;
    state_sel = '0; current6 = '0; state_sel6 = '0;
    m_thr = 200; m_leak = 1; m_ref = 2; m_total = 0;
    for (int k = 0; k < 4; k++) begin
      m_u[k] = 0; m_r[k] = 0; m_spk[k] = 0;
    end

    // Reset with full current, then default-config integration of ch0 at I=100.
    tbl[0]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 0,   0, 0};
    tbl[1]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 0,   0, 0};
    tbl[2]  = '{1'b1, 1'b1, 32'd100,       100, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 32'd100,       150, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 32'd100,       175, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 32'd100,       188, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 32'd100,       194, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 32'd100,       197, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 32'd100,       199, 0, 0};
    tbl[9]  = '{1'b1, 1'b1, 32'd100,       0,   1, 1};
    tbl[10] = '{1'b1, 1'b1, 32'd100,       0,   0, 1};
    tbl[11] = '{1'b1, 1'b1, 32'd100,       0,   0, 1};
    tbl[12] = '{1'b1, 1'b1, 32'd100,       100, 0, 1};

    for (int i = 0; i < 13; i++) begin
      rst_n = tbl[i].rst_n; ena = tbl[i].ena; current = tbl[i].cur; state_sel = 2'd0;
      applyStimulus();
      checkOutput($sformatf("vec%0d state_out", i), int'(state_out), tbl[i].exp_state);
      checkOutput($sformatf("vec%0d spike_out", i), int'(spike_out), tbl[i].exp_spike);
      checkOutput($sformatf("vec%0d spike_total", i), int'(spike_total), tbl[i].exp_total);
    end

    // No leak with refractory period: ch1 at I=50 fires every 6 updates.
    doReset();
    writeCfg(200, 0, 2);
    ena = 1'b1; current = 32'd50 << 8; state_sel = 2'd1;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus();
      if (i == 3) checkOutput("noleak u3", int'(state_out), 150);
      if (i == 4) checkOutput("noleak spike4", int'(spike_out), 2);
      if (i == 5) checkOutput("noleak refrac5", int'(spike_out), 0);
    end
    checkOutput("noleak total30", int'(spike_total), 5);
    checkModel("noleak");

    // Saturation: 130+130 clamps to 255 and fires instead of wrapping to 4.
    doReset();
    writeCfg(250, 0, 2);
    ena = 1'b1; current = 32'd130 << 16; state_sel = 2'd2;
    applyStimulus();
    checkOutput("sat u1", int'(state_out), 130);
    checkOutput("sat spike1", int'(spike_out), 0);
    applyStimulus();
    checkOutput("sat spike2", int'(spike_out), 4);
    checkOutput("sat u2", int'(state_out), 0);

    // Freeze mid-integration, then a threshold write on the firing edge.
    doReset();
    ena = 1'b1; current = 32'd100; state_sel = 2'd0;
    repeat (3) applyStimulus();
    checkOutput("freeze pre", int'(state_out), 175);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput($sformatf("freeze u%0d", i), int'(state_out), 175);
      checkOutput($sformatf("freeze spike%0d", i), int'(spike_out), 0);
    end
    ena = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("resume u", int'(state_out), 199);
    cfg_we = 1'b1; cfg_threshold = 8'd255; cfg_leak_shift = 3'd1; cfg_refrac = 3'd2;
    applyStimulus();
    cfg_we = 1'b0;
    checkOutput("cfgtiming spike", int'(spike_out), 1);
    checkOutput("cfgtiming total", int'(spike_total), 1);
    ena = 1'b0;
    applyStimulus();
    checkOutput("ena0 spike clear", int'(spike_out), 0);
    checkOutput("ena0 total hold", int'(spike_total), 1);
    ena = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("refrac held u", int'(state_out), 0);
    checkOutput("refrac held spike", int'(spike_out), 0);
    applyStimulus();
    checkOutput("restart u", int'(state_out), 100);
    checkModel("freeze");

    // Counter wrap: every channel fires every cycle with threshold 0 and no refractory.
    doReset();
    writeCfg(0, 1, 0);
    ena = 1'b1; current = '0;
    repeat (16383) applyStimulus();
    checkOutput("wrap total FFFC", int'(spike_total), 16'hFFFC);
    checkOutput("wrap spikes", int'(spike_out), 15);
    applyStimulus();
    checkOutput("wrap total 0", int'(spike_total), 0);
    checkModel("wrap");

    // Out-of-range readback on a 6-channel instance.
    doReset();
    ena = 1'b1; current6 = {6{8'd60}};
    applyStimulus();
    state_sel6 = 3'd5; #1;
    checkOutput("sel5 state", int'(state_out6), 60);
    state_sel6 = 3'd6; #1;
    checkOutput("sel6 state", int'(state_out6), 0);
    state_sel6 = 3'd7; #1;
    checkOutput("sel7 state", int'(state_out6), 0);

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      ena    = ($urandom_range(0, 9) != 0);
      cfg_we = ($urandom_range(0, 19) == 0);
      cfg_threshold  = 8'($urandom_range(0, 255));
      cfg_leak_shift = 3'($urandom_range(0, 7));
      cfg_refrac     = 3'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) current[8*k +: 8] = 8'($urandom_range(0, 120));
      applyStimulus();
      checkModel($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
